// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: E-stage sequencer for multi-cycle multiply/divide and the HI/LO register pair
`ifndef ALU_MULT
`define ALU_MULT  5'b10000
`endif
`ifndef ALU_MULTU
`define ALU_MULTU 5'b10001
`endif
`ifndef ALU_DIV
`define ALU_DIV   5'b10010
`endif
`ifndef ALU_DIVU
`define ALU_DIVU  5'b10011
`endif
`ifndef ALU_MTHI
`define ALU_MTHI  5'b10100
`endif
`ifndef ALU_MTLO
`define ALU_MTLO  5'b10101
`endif

module muldiv_ctrl #(
  parameter int MUL_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  alucontrolE,
  input  logic        validE,
  input  logic        flushE,
  input  logic        stallE_ext,
  input  logic [31:0] srcaE,
  input  logic [31:0] srcbE,
  output logic        stall_o,
  output logic        busy_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);
  localparam logic [4:0] LAST_MUL = 5'(MUL_LAT - 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t      r_state;
  logic [4:0]  r_cnt;
  logic        r_sgn, r_qneg, r_rneg;
  logic [31:0] r_a, r_b, r_rem;

  logic        w_mul, w_div, w_sgn, w_go, w_start_mul, w_start_div, w_last;
  logic [63:0] w_ma, w_mb, w_prod;
  logic [32:0] w_sh;
  logic        w_qb;
  logic [31:0] w_rem_n, w_q_n, w_q_fin, w_r_fin;

  assign w_mul       = (alucontrolE == `ALU_MULT) || (alucontrolE == `ALU_MULTU);
  assign w_div       = (alucontrolE == `ALU_DIV)  || (alucontrolE == `ALU_DIVU);
  assign w_sgn       = (alucontrolE == `ALU_MULT) || (alucontrolE == `ALU_DIV);
  assign w_go        = (r_state == S_IDLE) && validE && !flushE;
  assign w_start_mul = w_go && w_mul;
  assign w_start_div = w_go && w_div && (srcbE != 32'd0);
  assign w_last      = ((r_state == S_MUL) && (r_cnt == LAST_MUL)) || ((r_state == S_DIV) && (r_cnt == 5'd31));

  // Stall holds E from the start cycle until (but not including) the last busy cycle
  assign stall_o = !flushE && (w_start_mul || w_start_div || (((r_state == S_MUL) || (r_state == S_DIV)) && !w_last));
  assign busy_o  = (r_state != S_IDLE);

  // Sign-extended 64-bit operands; the truncated product is the exact signed/unsigned result
  assign w_ma   = {{32{r_sgn & r_a[31]}}, r_a};
  assign w_mb   = {{32{r_sgn & r_b[31]}}, r_b};
  assign w_prod = w_ma * w_mb;

  // One restoring step: 33-bit shifted remainder, dividend bits shift out of r_a MSB first
  assign w_sh    = {r_rem, r_a[31]};
  assign w_qb    = (w_sh >= {1'b0, r_b});
  assign w_rem_n = w_qb ? (w_sh[31:0] - r_b) : w_sh[31:0];
  assign w_q_n   = {r_a[30:0], w_qb};
  assign w_q_fin = r_qneg ? -w_q_n : w_q_n;
  assign w_r_fin = r_rneg ? -w_rem_n : w_rem_n;

  // FSM, operand latches, divider datapath and HI/LO commit
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 5'd0;
      r_sgn   <= 1'b0;
      r_qneg  <= 1'b0;
      r_rneg  <= 1'b0;
      r_a     <= 32'd0;
      r_b     <= 32'd0;
      r_rem   <= 32'd0;
      hi_o    <= 32'd0;
      lo_o    <= 32'd0;
    end else if (flushE) begin
      r_state <= S_IDLE;
      r_cnt   <= 5'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_go && (alucontrolE == `ALU_MTHI)) hi_o <= srcaE;
          if (w_go && (alucontrolE == `ALU_MTLO)) lo_o <= srcaE;
          r_cnt <= 5'd0;
          if (w_start_mul) begin
            r_a     <= srcaE;
            r_b     <= srcbE;
            r_sgn   <= w_sgn;
            r_state <= S_MUL;
          end else if (w_start_div) begin
            r_a     <= (w_sgn && srcaE[31]) ? -srcaE : srcaE;
            r_b     <= (w_sgn && srcbE[31]) ? -srcbE : srcbE;
            r_rem   <= 32'd0;
            r_qneg  <= w_sgn && (srcaE[31] ^ srcbE[31]);
            r_rneg  <= w_sgn && srcaE[31];
            r_state <= S_DIV;
          end
        end
        S_MUL: begin
          r_cnt <= w_last ? 5'd0 : r_cnt + 5'd1;
          if (w_last) begin
            hi_o    <= w_prod[63:32];
            lo_o    <= w_prod[31:0];
            r_state <= stallE_ext ? S_DONE : S_IDLE;
          end
        end
        S_DIV: begin
          r_a   <= w_q_n;
          r_rem <= w_rem_n;
          r_cnt <= w_last ? 5'd0 : r_cnt + 5'd1;
          if (w_last) begin
            lo_o    <= w_q_fin;
            hi_o    <= w_r_fin;
            r_state <= stallE_ext ? S_DONE : S_IDLE;
          end
        end
        S_DONE: r_state <= stallE_ext ? S_DONE : S_IDLE;
      endcase
    end
  end
endmodule
